// File: rtl/ahblite_busmatrix_inputstage.sv
// ---------------------------------------------------------------------------
// ahblite_busmatrix_inputstage
//
// Per-master input stage of the AHB-Lite bus matrix (one per master port).
// When the targeted output stage has not granted this port, the master's
// address phase is captured and the master is stalled until the grant
// arrives. The held (or live) address phase is presented to the output
// stage together with a TRANS_HOLD request. During the data phase the
// slave's HREADYOUT/HRESP are returned to the master.
//
// Ports
//   HCLK, HRESETn        clock, asynchronous active-low reset
//   HSEL..HPROT, HREADY  master-side address phase and bus HREADY
//   HREADYOUT, HRESP     ready / response back to the master
//   HSEL_O..HPROT_O      address phase toward the output stage
//   TRANS_HOLD           transfer request toward the output stage
//   ACTIVE               output stage has granted this port
//   HREADY_O             slave-facing HREADY from the output stage
//   HREADYOUT_S, HRESP_S slave ready / response through the decoder
// ---------------------------------------------------------------------------
module ahblite_busmatrix_inputstage #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic                  HSEL_O,
    output logic [ADDR_WIDTH-1:0] HADDR_O,
    output logic [1:0]            HTRANS_O,
    output logic                  HWRITE_O,
    output logic [2:0]            HSIZE_O,
    output logic [2:0]            HBURST_O,
    output logic [3:0]            HPROT_O,
    output logic                  TRANS_HOLD,
    input  logic                  ACTIVE,
    input  logic                  HREADY_O,
    input  logic                  HREADYOUT_S,
    input  logic                  HRESP_S
);

    typedef struct packed {
        logic                  sel;
        logic [ADDR_WIDTH-1:0] addr;
        logic [1:0]            trans;
        logic                  write;
        logic [2:0]            size;
        logic [2:0]            burst;
        logic [3:0]            prot;
    } aphase_t;

    aphase_t live_phase;
    aphase_t held_phase;
    aphase_t out_phase;

    logic pend;
    logic dphase;
    logic new_trans;
    logic accept;

    assign live_phase = '{HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT};

    // HTRANS[1] distinguishes NONSEQ/SEQ from IDLE/BUSY, so IDLE and BUSY
    // never raise a request or a pending hold.
    assign new_trans  = HSEL & HTRANS[1] & HREADY;
    assign TRANS_HOLD = pend | new_trans;
    assign accept     = ACTIVE & HREADY_O & TRANS_HOLD;

    // The master-side HREADY is low whenever pend is set, so the capture
    // register naturally keeps the held phase until the grant arrives.
    // NOTE: sequential state uses non-blocking (<=) so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            held_phase <= '0;
        end else if (HREADY) begin
            held_phase <= live_phase;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pend <= 1'b0;
        end else if (pend & accept) begin
            pend <= 1'b0;
        end else if (new_trans & ~accept) begin
            pend <= 1'b1;
        end
    end

    // dphase records that the address phase just issued on the slave side
    // was a real transfer owned by this port, so the next slave ready and
    // response belong to our master.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dphase <= 1'b0;
        end else if (HREADY_O) begin
            dphase <= accept & out_phase.trans[1];
        end
    end

    // NOTE: every output of this always_comb gets a default first so no
    // path through the block can leave a value unassigned (no latches).
    always_comb begin
        out_phase = live_phase;
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        if (pend) begin
            out_phase = held_phase;
            HREADYOUT = 1'b0;
        end else if (dphase) begin
            HREADYOUT = HREADYOUT_S;
        end
        // Response is pure pass-through during the data phase, including
        // both cycles of a two-cycle ERROR.
        if (dphase) begin
            HRESP = HRESP_S;
        end
    end

    assign HSEL_O   = out_phase.sel;
    assign HADDR_O  = out_phase.addr;
    assign HTRANS_O = out_phase.trans;
    assign HWRITE_O = out_phase.write;
    assign HSIZE_O  = out_phase.size;
    assign HBURST_O = out_phase.burst;
    assign HPROT_O  = out_phase.prot;

endmodule

// File: tb/tb_ahblite_busmatrix_inputstage.sv
// ---------------------------------------------------------------------------
// tb_ahblite_busmatrix_inputstage
//
// Directed bench for the bus-matrix input stage: reset, immediate grant,
// delayed grant, slave wait states, ERROR pass-through, INCR4 burst under
// contention and reset while a phase is held. The master-bus HREADY is
// this port's own HREADYOUT (single master on the bus).
// ---------------------------------------------------------------------------
module tb_ahblite_busmatrix_inputstage;

    localparam int AW = 32;
    localparam logic [1:0] IDLE = 2'b00, NONSEQ = 2'b10, SEQ = 2'b11;

    logic          HCLK = 1'b0;
    logic          HRESETn;
    logic          hsel;
    logic [AW-1:0] haddr;
    logic [1:0]    htrans;
    logic          hwrite;
    logic [2:0]    hsize;
    logic [2:0]    hburst;
    logic [3:0]    hprot;
    logic          hready;
    logic          hreadyout;
    logic          hresp;
    logic          hsel_o;
    logic [AW-1:0] haddr_o;
    logic [1:0]    htrans_o;
    logic          hwrite_o;
    logic [2:0]    hsize_o;
    logic [2:0]    hburst_o;
    logic [3:0]    hprot_o;
    logic          trans_hold;
    logic          active;
    logic          hready_o;
    logic          hreadyout_s;
    logic          hresp_s;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] acc_log[$];
    logic [31:0] exp_acc[8] = '{32'h2000_0010, 32'h0000_0100, 32'h3000_0000,
                                32'h4000_0000, 32'h5000_0000, 32'h5000_0004,
                                32'h5000_0008, 32'h5000_000C};

    always #5 HCLK = ~HCLK;

    assign hready = hreadyout;

    ahblite_busmatrix_inputstage #(.ADDR_WIDTH(AW)) dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .HSEL        (hsel),
        .HADDR       (haddr),
        .HTRANS      (htrans),
        .HWRITE      (hwrite),
        .HSIZE       (hsize),
        .HBURST      (hburst),
        .HPROT       (hprot),
        .HREADY      (hready),
        .HREADYOUT   (hreadyout),
        .HRESP       (hresp),
        .HSEL_O      (hsel_o),
        .HADDR_O     (haddr_o),
        .HTRANS_O    (htrans_o),
        .HWRITE_O    (hwrite_o),
        .HSIZE_O     (hsize_o),
        .HBURST_O    (hburst_o),
        .HPROT_O     (hprot_o),
        .TRANS_HOLD  (trans_hold),
        .ACTIVE      (active),
        .HREADY_O    (hready_o),
        .HREADYOUT_S (hreadyout_s),
        .HRESP_S     (hresp_s)
    );

    // Log every address phase the output stage accepts (inputs are stable
    // at the falling edge, so this is what the rising edge will see).
    always @(negedge HCLK) begin
        if (HRESETn && active && hready_o && trans_hold) begin
            acc_log.push_back(haddr_o);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive master and slave-side inputs just after the
    // rising edge, then let combinational outputs settle before checking.
    task automatic step(input logic s, input logic [1:0] t, input logic w,
                        input logic [31:0] a, input logic [2:0] b,
                        input logic act, input logic rdy_o,
                        input logic rdy_s, input logic rsp_s);
        @(posedge HCLK);
        #1;
        hsel        = s;
        htrans      = t;
        hwrite      = w;
        haddr       = a;
        hburst      = b;
        hsize       = 3'd2;
        hprot       = 4'b0011;
        active      = act;
        hready_o    = rdy_o;
        hreadyout_s = rdy_s;
        hresp_s     = rsp_s;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] obs;

        // Reset with random address/control; master in reset drives IDLE.
        HRESETn     = 1'b0;
        hsel        = 1'($urandom);
        haddr       = $urandom;
        htrans      = IDLE;
        hwrite      = 1'($urandom);
        hsize       = 3'($urandom);
        hburst      = 3'($urandom);
        hprot       = 4'($urandom);
        active      = 1'($urandom);
        hready_o    = 1'b1;
        hreadyout_s = 1'($urandom);
        hresp_s     = 1'b1;
        repeat (2) @(posedge HCLK);
        #2;
        check("rst_hreadyout", 32'(hreadyout), 32'h1);
        check("rst_hresp", 32'(hresp), 32'h0);
        check("rst_trans_hold", 32'(trans_hold), 32'h0);
        check("rst_haddr_o_live", haddr_o, haddr);
        check("rst_hsel_o_live", 32'(hsel_o), 32'(hsel));
        @(negedge HCLK);
        HRESETn = 1'b1;

        // Immediate grant: NONSEQ write passes through in the same cycle.
        step(1, NONSEQ, 1, 32'h2000_0010, 3'd0, 1, 1, 1, 0);
        check("imm_haddr_o", haddr_o, 32'h2000_0010);
        check("imm_trans_hold", 32'(trans_hold), 32'h1);
        check("imm_hwrite_o", 32'(hwrite_o), 32'h1);
        check("imm_htrans_o", 32'(htrans_o), 32'(NONSEQ));
        check("imm_hsize_o", 32'(hsize_o), 32'h2);
        check("imm_hreadyout", 32'(hreadyout), 32'h1);
        step(0, IDLE, 0, 32'h2000_0014, 3'd0, 1, 0, 0, 0);
        check("imm_dph_wait", 32'(hreadyout), 32'h0);
        check("imm_dph_hold", 32'(trans_hold), 32'h0);
        check("imm_dph_hresp", 32'(hresp), 32'h0);
        step(0, IDLE, 0, 32'h2000_0014, 3'd0, 1, 1, 1, 0);
        check("imm_dph_ready", 32'(hreadyout), 32'h1);

        // Delayed grant: three stall cycles, address held at 0x100.
        step(1, NONSEQ, 0, 32'h0000_0100, 3'd0, 0, 1, 1, 0);
        check("dly_first_hreadyout", 32'(hreadyout), 32'h1);
        check("dly_first_trans_hold", 32'(trans_hold), 32'h1);
        check("dly_first_haddr_o", haddr_o, 32'h0000_0100);
        for (int i = 0; i < 3; i++) begin
            step(0, IDLE, 0, 32'hDEAD_0000, 3'd0, (i == 2), 1, 1, 0);
            check("dly_stall_hreadyout", 32'(hreadyout), 32'h0);
            check("dly_stall_trans_hold", 32'(trans_hold), 32'h1);
            check("dly_stall_haddr_o", haddr_o, 32'h0000_0100);
            check("dly_stall_htrans_o", 32'(htrans_o), 32'(NONSEQ));
            check("dly_stall_hsel_o", 32'(hsel_o), 32'h1);
        end
        step(0, IDLE, 0, 32'hDEAD_0000, 3'd0, 1, 1, 1, 0);
        check("dly_done_hreadyout", 32'(hreadyout), 32'h1);
        check("dly_done_trans_hold", 32'(trans_hold), 32'h0);
        check("dly_done_haddr_live", haddr_o, 32'hDEAD_0000);

        // Slave wait states: two data cycles with HREADYOUT_S low.
        step(1, NONSEQ, 1, 32'h3000_0000, 3'd0, 1, 1, 1, 0);
        check("ws_addr_hreadyout", 32'(hreadyout), 32'h1);
        for (int i = 0; i < 2; i++) begin
            step(0, IDLE, 0, 32'h3000_0000, 3'd0, 1, 0, 0, 0);
            check("ws_wait_hreadyout", 32'(hreadyout), 32'h0);
        end
        step(0, IDLE, 0, 32'h3000_0000, 3'd0, 1, 1, 1, 0);
        check("ws_end_hreadyout", 32'(hreadyout), 32'h1);

        // Two-cycle ERROR response passes through unchanged.
        step(1, NONSEQ, 0, 32'h4000_0000, 3'd0, 1, 1, 1, 0);
        check("err_addr_hresp", 32'(hresp), 32'h0);
        step(0, IDLE, 0, 32'h4000_0000, 3'd0, 1, 0, 0, 1);
        check("err_c1_hresp", 32'(hresp), 32'h1);
        check("err_c1_hreadyout", 32'(hreadyout), 32'h0);
        step(0, IDLE, 0, 32'h4000_0000, 3'd0, 1, 1, 1, 1);
        check("err_c2_hresp", 32'(hresp), 32'h1);
        check("err_c2_hreadyout", 32'(hreadyout), 32'h1);
        step(0, IDLE, 0, 32'h4000_0000, 3'd0, 1, 1, 1, 1);
        check("err_idle_hresp_masked", 32'(hresp), 32'h0);

        // INCR4 burst; grant drops for beat 3 and returns two cycles later.
        step(1, NONSEQ, 1, 32'h5000_0000, 3'd3, 1, 1, 1, 0);
        check("b1_htrans_o", 32'(htrans_o), 32'(NONSEQ));
        check("b1_hburst_o", 32'(hburst_o), 32'h3);
        step(1, SEQ, 1, 32'h5000_0004, 3'd3, 1, 1, 1, 0);
        check("b2_haddr_o", haddr_o, 32'h5000_0004);
        check("b2_htrans_o", 32'(htrans_o), 32'(SEQ));
        check("b2_hreadyout", 32'(hreadyout), 32'h1);
        step(1, SEQ, 1, 32'h5000_0008, 3'd3, 0, 1, 1, 0);
        check("b3_hreadyout", 32'(hreadyout), 32'h1);
        check("b3_trans_hold", 32'(trans_hold), 32'h1);
        for (int i = 0; i < 2; i++) begin
            step(1, SEQ, 1, 32'h5000_000C, 3'd3, (i == 1), 1, 1, 0);
            check("b3_held_hreadyout", 32'(hreadyout), 32'h0);
            check("b3_held_trans_hold", 32'(trans_hold), 32'h1);
            check("b3_held_haddr_o", haddr_o, 32'h5000_0008);
            check("b3_held_htrans_o", 32'(htrans_o), 32'(SEQ));
        end
        step(1, SEQ, 1, 32'h5000_000C, 3'd3, 1, 1, 1, 0);
        check("b4_haddr_o", haddr_o, 32'h5000_000C);
        check("b4_hreadyout", 32'(hreadyout), 32'h1);
        check("b4_trans_hold", 32'(trans_hold), 32'h1);
        step(0, IDLE, 0, 32'h5000_000C, 3'd0, 1, 1, 1, 0);
        check("burst_end_trans_hold", 32'(trans_hold), 32'h0);
        check("burst_end_hreadyout", 32'(hreadyout), 32'h1);

        // Every address phase accepted exactly once, in order.
        check("acc_count", 32'(acc_log.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            obs = (i < acc_log.size()) ? acc_log[i] : 32'hxxxx_xxxx;
            check($sformatf("acc_%0d", i), obs, exp_acc[i]);
        end

        // Reset while a phase is held clears the hold immediately.
        step(1, NONSEQ, 0, 32'h0000_0600, 3'd0, 0, 1, 1, 0);
        step(0, IDLE, 0, 32'h0000_0700, 3'd0, 0, 1, 1, 0);
        check("mid_pend_hreadyout", 32'(hreadyout), 32'h0);
        check("mid_pend_haddr_o", haddr_o, 32'h0000_0600);
        HRESETn = 1'b0;
        #1;
        check("mid_rst_hreadyout", 32'(hreadyout), 32'h1);
        check("mid_rst_trans_hold", 32'(trans_hold), 32'h0);
        check("mid_rst_haddr_live", haddr_o, 32'h0000_0700);
        @(negedge HCLK);
        HRESETn = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
